fsm_counter_mc: RTL and testbench
=================================

// Module: fsm_counter_mc
// PURPOSE
//  Multi-channel successor to the single-channel run/idle/running/done counter FSM.
//  NUM_CH independent channels each count a programmed number of cycles.
//  Modes per channel: one-shot or periodic auto-reload. Adds abort, sticky done flags and a masked IRQ.
//  Sits behind the AXI4-Lite register slave in the IP top. All control inputs come from slave registers.
// PARAMETERS
//  NUM_CH   4   number of independent counter channels (1..16)
//  CNT_BIT  31  width of the count target and of the live count per channel
// PORTS
//  clk            in   1               system clock (AXI aclk); single clock domain
//  reset_n        in   1               asynchronous active-low reset
//  i_run          in   NUM_CH          per-channel start pulse (level tolerated; only acted on in IDLE)
//  i_abort        in   NUM_CH          per-channel abort request
//  i_mode         in   NUM_CH          0 = one-shot, 1 = periodic; latched at start
//  i_num_cnt      in   NUM_CH*CNT_BIT  per-channel target N; channel c in bits [c*CNT_BIT +: CNT_BIT]
//  i_clr_done     in   NUM_CH          per-channel clear of the sticky done flag
//  i_irq_en       in   NUM_CH          per-channel interrupt enable
//  o_idle         out  NUM_CH          channel is in IDLE
//  o_running      out  NUM_CH          channel is in RUN
//  o_done         out  NUM_CH          1-cycle pulse; channel is in DONE
//  o_done_sticky  out  NUM_CH          set on DONE entry, held until cleared
//  o_cnt          out  NUM_CH*CNT_BIT  live count per channel, same packing as i_num_cnt
//  o_irq          out  1               |(o_done_sticky & i_irq_en)
// BEHAVIOUR
//  Reset (async): every channel goes to IDLE.
//   - o_idle = all 1.
//   - o_running, o_done, o_done_sticky, o_cnt and o_irq = 0.
//   - Latched target and latched mode = 0.
//  Per-channel state register encodings: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10. 2'b11 is illegal and returns to IDLE.
//  o_idle, o_running and o_done decode directly from the state register. There is no combinational path from inputs.
//  IDLE:
//   - i_run=1 and N!=0: latch N and i_mode, clear cnt to 0, go to RUN.
//   - i_run=1 and N==0: ignored; the channel stays in IDLE.
//  RUN:
//   - cnt increments by 1 each cycle.
//   - When cnt == N_latched-1, go to DONE. RUN therefore lasts exactly N cycles.
//  DONE (exactly 1 cycle):
//   - Set o_done_sticky.
//   - cnt holds its final value N-1.
//   - If the latched mode is periodic and the live i_num_cnt is nonzero: re-latch N from i_num_cnt, clear cnt to 0, go to RUN.
//   - Otherwise go to IDLE.
//  Latency from i_run sampled high at edge t:
//   - o_running is high from t+1 through t+N.
//   - o_done is high at t+N+1.
//   - One-shot: o_idle is high from t+N+2.
//   - Periodic: period is N+1 cycles.
//  o_cnt keeps its last value in IDLE and is cleared only at the next start.
//  Changing i_num_cnt or i_mode while in RUN has no effect until the next start or reload.
//  Abort:
//   - i_abort=1 in RUN or DONE sends the channel to IDLE on the next edge.
//   - Abort in RUN: no DONE pulse, no sticky set.
//   - Abort in DONE: the pulse already shown stands and the sticky is already set; the reload is suppressed.
//   - Abort beats run when both are asserted. Abort in IDLE is a no-op.
//  i_run while in RUN or DONE is ignored. There is no restart.
//  Sticky flag: set and i_clr_done in the same cycle leaves it set (set wins).
//  o_irq is registered: it follows the sticky and enable values with 1 cycle of latency.
//  Count width: cnt is never compared against a value >= 2^CNT_BIT, so no wrap can occur.
//   The all-ones target (N = 2^CNT_BIT-1) is legal.
//  Channels are fully independent; there is no arbitration or shared state except o_irq.
// TESTING
//  T1 one-shot: ch0 N=5, pulse run.
//   -> running for 5 cycles, done at cycle 6, idle at cycle 7.
//   -> sticky=1, o_cnt=4.
//  T2 periodic: ch1 N=3, mode=1, run.
//   -> done pulses every 4 cycles.
//   -> set i_num_cnt=2 mid-run: the following period is 3 cycles.
//   -> set i_num_cnt=0: the channel returns to IDLE after the current DONE.
//  T3 abort: ch2 N=10, abort at the 4th running cycle.
//   -> IDLE next cycle, no done pulse, sticky=0, o_cnt=3.
//   -> abort and run in the same cycle while IDLE: the channel stays in IDLE.
//  T4 sticky/IRQ: irq_en=4'b0010, ch1 completes.
//   -> o_irq=1 one cycle after the sticky sets.
//   -> clr_done asserted in the same cycle as a new DONE: the sticky stays 1.
//   -> clear alone: o_irq=0 next cycle.
//  T5 corners:
//   -> run with N=0: ignored.
//   -> N=1: running for 1 cycle, done on the next cycle.
//   -> all 4 channels started on the same cycle with different N: independent, exact completion times.
//   -> reset_n asserted mid-RUN: all outputs return to reset values immediately.

Source files
------------

// File: rtl/fsm_counter_mc_if.sv
// Control/status bundle between the register slave and the multi-channel
// counter. Packed per-channel lanes: [ch] selects a channel, and
// i_num_cnt/o_cnt put channel c in bits [c*CNT_BIT +: CNT_BIT].
interface fsm_counter_mc_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_BIT = 31
);
  logic [NUM_CH-1:0]              i_run;
  logic [NUM_CH-1:0]              i_abort;
  logic [NUM_CH-1:0]              i_mode;
  logic [NUM_CH-1:0][CNT_BIT-1:0] i_num_cnt;
  logic [NUM_CH-1:0]              i_clr_done;
  logic [NUM_CH-1:0]              i_irq_en;
  logic [NUM_CH-1:0]              o_idle;
  logic [NUM_CH-1:0]              o_running;
  logic [NUM_CH-1:0]              o_done;
  logic [NUM_CH-1:0]              o_done_sticky;
  logic [NUM_CH-1:0][CNT_BIT-1:0] o_cnt;
  logic                           o_irq;

  // Register slave side drives controls and reads status.
  modport master (
    output i_run, i_abort, i_mode, i_num_cnt, i_clr_done, i_irq_en,
    input  o_idle, o_running, o_done, o_done_sticky, o_cnt, o_irq
  );

  // Counter side.
  modport slave (
    input  i_run, i_abort, i_mode, i_num_cnt, i_clr_done, i_irq_en,
    output o_idle, o_running, o_done, o_done_sticky, o_cnt, o_irq
  );
endinterface

// File: rtl/fsm_counter_mc.sv
// Multi-channel cycle counter. Each channel is an IDLE/RUN/DONE FSM that
// counts a latched target N (RUN lasts N cycles, DONE lasts one), with
// one-shot or periodic reload, abort, a sticky done flag, and a shared
// registered IRQ.

// One counter channel.
module fsm_counter_ch #(
  parameter int CNT_BIT = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               abort,
  input  logic               mode,
  input  logic [CNT_BIT-1:0] num_cnt,
  input  logic               clr_done,
  output logic               idle,
  output logic               running,
  output logic               done,
  output logic               sticky,
  output logic [CNT_BIT-1:0] cnt
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [CNT_BIT-1:0] ONE = CNT_BIT'(1);

  state_e             state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [CNT_BIT-1:0] n_q, n_d;
  logic               mode_q, mode_d;
  logic               sticky_q, sticky_d;
  logic               set_sticky;

  // State, count, latched target/mode and sticky flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      mode_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      sticky_q <= sticky_d;
    end
  end

  // Next state. Abort always wins over run/reload; a zero target never
  // starts or reloads, so n_q is nonzero whenever n_q - 1 is used.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    mode_d     = mode_q;
    set_sticky = 1'b0;
    case (state_q)
      IDLE: begin
        if (run && !abort && num_cnt != '0) begin
          state_d = RUN;
          n_d     = num_cnt;
          mode_d  = mode;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == n_q - ONE) begin
          state_d    = DONE;
          set_sticky = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DONE: begin
        if (!abort && mode_q && num_cnt != '0) begin
          state_d = RUN;
          n_d     = num_cnt;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Setting on DONE entry beats a simultaneous clear.
    sticky_d = set_sticky | (sticky_q & ~clr_done);
  end

  assign idle    = (state_q == IDLE);
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign sticky  = sticky_q;
  assign cnt     = cnt_q;
endmodule

module fsm_counter_mc #(
  parameter int NUM_CH  = 4,
  parameter int CNT_BIT = 31
) (
  input logic             clk,
  input logic             reset_n,
  fsm_counter_mc_if.slave bus
);
  logic [NUM_CH-1:0]              idle_v, running_v, done_v, sticky_v;
  logic [NUM_CH-1:0][CNT_BIT-1:0] cnt_v;
  logic                           irq_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fsm_counter_ch #(.CNT_BIT(CNT_BIT)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .run      (bus.i_run[c]),
      .abort    (bus.i_abort[c]),
      .mode     (bus.i_mode[c]),
      .num_cnt  (bus.i_num_cnt[c]),
      .clr_done (bus.i_clr_done[c]),
      .idle     (idle_v[c]),
      .running  (running_v[c]),
      .done     (done_v[c]),
      .sticky   (sticky_v[c]),
      .cnt      (cnt_v[c])
    );
  end

  // IRQ trails the sticky/enable combination by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |(sticky_v & bus.i_irq_en);
  end

  assign bus.o_idle        = idle_v;
  assign bus.o_running     = running_v;
  assign bus.o_done        = done_v;
  assign bus.o_done_sticky = sticky_v;
  assign bus.o_cnt         = cnt_v;
  assign bus.o_irq         = irq_q;
endmodule

// File: tb/tb_fsm_counter_mc.sv
// Bench for fsm_counter_mc: directed scenarios plus randomized traffic, all
// checked every cycle against a timeline model (cycles elapsed since start).
module tb_fsm_counter_mc;
  localparam int NUM_CH  = 4;
  localparam int CNT_BIT = 5;
  localparam int ALL1    = (1 << CNT_BIT) - 1;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  fsm_counter_mc_if #(.NUM_CH(NUM_CH), .CNT_BIT(CNT_BIT)) bus ();
  fsm_counter_mc #(.NUM_CH(NUM_CH), .CNT_BIT(CNT_BIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: a channel is active from its start; el = edges since start
  // (1 right after it). Running for el in 1..N, done at el = N+1.
  bit act [NUM_CH];
  int el  [NUM_CH];
  int nn  [NUM_CH];
  int cm  [NUM_CH];
  bit md  [NUM_CH];
  bit stk [NUM_CH];
  bit irqm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      act[c] = 0; el[c] = 0; nn[c] = 0; cm[c] = 0; md[c] = 0; stk[c] = 0;
    end
    irqm = 0;
  endtask

  task automatic model_edge();
    bit nirq;
    nirq = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      bit set;
      int num;
      set = 0;
      num = int'(bus.i_num_cnt[c]);
      nirq |= stk[c] & bus.i_irq_en[c];
      if (!act[c]) begin
        if (bus.i_run[c] && !bus.i_abort[c] && num != 0) begin
          act[c] = 1; nn[c] = num; md[c] = bus.i_mode[c]; el[c] = 1; cm[c] = 0;
        end
      end else if (el[c] <= nn[c]) begin
        if (bus.i_abort[c]) act[c] = 0;
        else begin
          el[c]++;
          if (el[c] == nn[c] + 1) set = 1;
          else cm[c] = el[c] - 1;
        end
      end else begin
        if (bus.i_abort[c] || !(md[c] && num != 0)) act[c] = 0;
        else begin
          nn[c] = num; el[c] = 1; cm[c] = 0;
        end
      end
      stk[c] = set | (stk[c] & !bus.i_clr_done[c]);
    end
    irqm = nirq;
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0]              ei, er, ed, es;
    logic [NUM_CH-1:0][CNT_BIT-1:0] ec;
    for (int c = 0; c < NUM_CH; c++) begin
      ei[c] = !act[c];
      er[c] = act[c] && el[c] <= nn[c];
      ed[c] = act[c] && el[c] == nn[c] + 1;
      es[c] = stk[c];
      ec[c] = CNT_BIT'(cm[c]);
    end
    chk("idle",    64'(bus.o_idle),        64'(ei));
    chk("running", 64'(bus.o_running),     64'(er));
    chk("done",    64'(bus.o_done),        64'(ed));
    chk("sticky",  64'(bus.o_done_sticky), 64'(es));
    chk("cnt",     64'(bus.o_cnt),         64'(ec));
    chk("irq",     64'(bus.o_irq),         64'(irqm));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic start(input int ch, input int n, input bit m);
    bus.i_num_cnt[ch] = CNT_BIT'(n);
    bus.i_mode[ch]    = m;
    bus.i_run[ch]     = 1'b1;
    step();
    bus.i_run[ch]     = 1'b0;
  endtask

  // Steps until o_done[ch]; n = steps taken. An expired budget shows as a failed check.
  task automatic wait_done(input int ch, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.o_done[ch] && n < budget);
    chk("done_seen", 64'(bus.o_done[ch]), 64'(1));
  endtask

  initial begin
    int c;
    int dt [NUM_CH];
    reset_n        = 1'b0;
    bus.i_run      = '0;
    bus.i_abort    = '0;
    bus.i_mode     = '0;
    bus.i_num_cnt  = '0;
    bus.i_clr_done = '0;
    bus.i_irq_en   = '0;
    #1;
    model_reset();
    compare_all();
    chk("rst_idle", 64'(bus.o_idle), 64'hF);
    #11 reset_n = 1'b1;

    // One-shot N=5 on ch0.
    start(0, 5, 0);
    chk("t1_run0", 64'(bus.o_running[0]), 64'(1));
    wait_done(0, 20, c);
    chk("t1_done_lat", 64'(c), 64'(5));
    step();
    chk("t1_idle", 64'(bus.o_idle[0]), 64'(1));
    chk("t1_sticky", 64'(bus.o_done_sticky[0]), 64'(1));
    chk("t1_cnt", 64'(bus.o_cnt[0]), 64'(4));

    // Periodic N=3 on ch1, retarget to 2 mid-run, then to 0.
    start(1, 3, 1);
    wait_done(1, 20, c);
    wait_done(1, 20, c);
    chk("t2_period3", 64'(c), 64'(4));
    step();
    bus.i_num_cnt[1] = CNT_BIT'(2);
    wait_done(1, 20, c);
    chk("t2_tail", 64'(c), 64'(3));
    wait_done(1, 20, c);
    chk("t2_period2", 64'(c), 64'(3));
    bus.i_num_cnt[1] = '0;
    step();
    chk("t2_stop", 64'(bus.o_idle[1]), 64'(1));
    bus.i_mode = '0;

    // Abort on the 4th running cycle of ch2, then abort+run while idle.
    start(2, 10, 0);
    repeat (3) step();
    bus.i_abort[2] = 1'b1;
    step();
    bus.i_abort[2] = 1'b0;
    chk("t3_idle", 64'(bus.o_idle[2]), 64'(1));
    chk("t3_cnt", 64'(bus.o_cnt[2]), 64'(3));
    chk("t3_sticky", 64'(bus.o_done_sticky[2]), 64'(0));
    bus.i_run[2] = 1'b1;
    bus.i_abort[2] = 1'b1;
    step();
    bus.i_run[2] = 1'b0;
    bus.i_abort[2] = 1'b0;
    chk("t3_abort_run", 64'(bus.o_idle[2]), 64'(1));

    // Sticky / IRQ on ch1.
    bus.i_clr_done = '1;
    step();
    bus.i_clr_done = '0;
    bus.i_irq_en = 4'b0010;
    start(1, 2, 0);
    wait_done(1, 10, c);
    chk("t4_irq_lag", 64'(bus.o_irq), 64'(0));
    step();
    chk("t4_irq", 64'(bus.o_irq), 64'(1));
    start(1, 2, 0);
    step();
    bus.i_clr_done[1] = 1'b1;
    step();
    bus.i_clr_done[1] = 1'b0;
    chk("t4_set_wins", 64'(bus.o_done_sticky[1]), 64'(1));
    bus.i_clr_done[1] = 1'b1;
    step();
    bus.i_clr_done[1] = 1'b0;
    chk("t4_cleared", 64'(bus.o_done_sticky[1]), 64'(0));
    step();
    chk("t4_irq_off", 64'(bus.o_irq), 64'(0));

    // Corners: N=0, N=1, all-ones, simultaneous starts, reset mid-run.
    bus.i_num_cnt[3] = '0;
    bus.i_run[3] = 1'b1;
    step();
    bus.i_run[3] = 1'b0;
    chk("t5_n0", 64'(bus.o_idle[3]), 64'(1));
    start(0, 1, 0);
    chk("t5_n1_run", 64'(bus.o_running[0]), 64'(1));
    step();
    chk("t5_n1_done", 64'(bus.o_done[0]), 64'(1));
    start(3, ALL1, 0);
    wait_done(3, 40, c);
    chk("t5_all1_lat", 64'(c), 64'(ALL1));
    step();
    chk("t5_all1_cnt", 64'(bus.o_cnt[3]), 64'(ALL1 - 1));
    bus.i_num_cnt[0] = CNT_BIT'(3);
    bus.i_num_cnt[1] = CNT_BIT'(6);
    bus.i_num_cnt[2] = CNT_BIT'(1);
    bus.i_num_cnt[3] = CNT_BIT'(9);
    bus.i_run = '1;
    step();
    bus.i_run = '0;
    for (int k = 0; k < NUM_CH; k++) dt[k] = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      for (int k = 0; k < NUM_CH; k++) if (bus.o_done[k]) dt[k] = i;
    end
    chk("t5_par0", 64'(dt[0]), 64'(3));
    chk("t5_par1", 64'(dt[1]), 64'(6));
    chk("t5_par2", 64'(dt[2]), 64'(1));
    chk("t5_par3", 64'(dt[3]), 64'(9));
    bus.i_num_cnt = {NUM_CH{CNT_BIT'(20)}};
    bus.i_run = '1;
    step();
    bus.i_run = '0;
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("t5_rst_idle", 64'(bus.o_idle), 64'hF);
    chk("t5_rst_cnt", 64'(bus.o_cnt), 64'(0));
    #2 reset_n = 1'b1;

    // Randomized traffic; ch3 is never aborted so long targets can finish.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int r;
        r = int'($urandom_range(0, 9));
        bus.i_num_cnt[k]  = (r == 9) ? CNT_BIT'(ALL1) : CNT_BIT'(r);
        bus.i_run[k]      = ($urandom_range(0, 3) == 0);
        bus.i_mode[k]     = $urandom_range(0, 1) == 1;
        bus.i_abort[k]    = (k != NUM_CH - 1) && ($urandom_range(0, 31) == 0);
        bus.i_clr_done[k] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 15) == 0) bus.i_irq_en = NUM_CH'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
